// File: rtl/vector_mac_pkg.sv
// rtl/vector_mac_pkg.sv - shared types, widths and element-slot helper for vector_mac
package vector_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int PROD_W    = 2 * DEF_WIDTH;
  localparam int DEF_RES_W = PROD_W + 16;

  // Position inside the presented chunk of the element a lane works on.
  function automatic logic [31:0] elem_slot(input logic [31:0] base,
                                            input logic [31:0] lane,
                                            input logic [31:0] n);
    return (base + lane) % n;
  endfunction

endpackage

// File: rtl/vector_mac_lane.sv
// rtl/vector_mac_lane.sv - one signed multiply lane with tail mask, sign-extended product
module mac_lane #(
  parameter int WIDTH = 16,
  parameter int RES_W = 48
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    valid,
  output logic signed [RES_W-1:0] product
);

  logic signed [2*WIDTH-1:0] prod_full;

  assign prod_full = a * b;
  assign product   = valid ? RES_W'(prod_full) : '0;

endmodule

// File: rtl/vector_mac.sv
// rtl/vector_mac.sv - streaming signed dot-product engine for one matrix row
module vector_mac
  import vector_mac_pkg::*;
#(
  parameter int N        = 8,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_MACS = 2,
  parameter int RES_W    = 2 * WIDTH + 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             row_size,
  input  logic [N*WIDTH-1:0]      vector_A,
  input  logic [N*WIDTH-1:0]      vector_B,
  output logic signed [RES_W-1:0] result,
  output logic [31:0]             counter,
  output logic                    done
);

  state_t                  state;
  state_t                  state_next;
  logic [31:0]             row_len;
  logic signed [RES_W-1:0] acc;
  logic signed [RES_W-1:0] lane_sum;
  logic signed [RES_W-1:0] prods [NUM_MACS];

  for (genvar m = 0; m < NUM_MACS; m++) begin : g_lane
    logic [31:0] slot;
    logic [32:0] elem;

    assign slot = elem_slot(counter, 32'(m), 32'(N));
    assign elem = {1'b0, counter} + 33'(m);

    mac_lane #(
      .WIDTH (WIDTH),
      .RES_W (RES_W)
    ) u_lane (
      .a       (vector_A[slot*WIDTH +: WIDTH]),
      .b       (vector_B[slot*WIDTH +: WIDTH]),
      .valid   (elem < {1'b0, row_len}),
      .product (prods[m])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int m = 0; m < NUM_MACS; m++) begin
      lane_sum = lane_sum + prods[m];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (row_size == 32'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        // 33-bit compare so a row near 2^32 elements cannot wrap past the end.
        if (({1'b0, counter} + 33'(NUM_MACS)) >= {1'b0, row_len}) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      counter <= '0;
      row_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_len <= row_size;
            acc     <= '0;
            counter <= '0;
          end
        end
        BUSY: begin
          acc     <= acc + lane_sum;
          counter <= counter + 32'(NUM_MACS);
        end
        default: ;
      endcase
    end
  end

  assign result = acc;
  assign done   = (state == DONE);

endmodule

// File: tb/tb_vector_mac.sv
// tb/tb_vector_mac.sv - directed self-checking bench for vector_mac
module tb_vector_mac;

  localparam int N        = 8;
  localparam int W        = 16;
  localparam int NUM_MACS = 2;
  localparam int RES_W    = 48;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [31:0]             row_size;
  logic [N*W-1:0]          vec_a;
  logic [N*W-1:0]          vec_b;
  logic signed [RES_W-1:0] result;
  logic [31:0]             counter;
  logic                    done;

  int          checks;
  int          failures;
  int          mode;
  logic [31:0] hist [64];

  vector_mac #(
    .N        (N),
    .WIDTH    (W),
    .NUM_MACS (NUM_MACS),
    .RES_W    (RES_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row_size (row_size),
    .vector_A (vec_a),
    .vector_B (vec_b),
    .result   (result),
    .counter  (counter),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feeder presents chunk counter/N; mode 3 makes every chunk distinct.
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin vec_a[i*W +: W] = 16'(i + 1);         vec_b[i*W +: W] = 16'd1; end
        1: begin vec_a[i*W +: W] = 16'd2;              vec_b[i*W +: W] = 16'd3; end
        2: begin vec_a[i*W +: W] = 16'hFFFD;           vec_b[i*W +: W] = 16'd4; end
        default: begin vec_a[i*W +: W] = 16'(counter / N + 1); vec_b[i*W +: W] = 16'd1; end
      endcase
    end
  end

  // lat = number of edges after the accepting edge until done is seen; -1 on timeout.
  task automatic run_row(input logic [31:0] rs, input int poke_at, output int lat);
    int k;
    @(negedge clk);
    start    = 1'b1;
    row_size = rs;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    k     = 0;
    while (k < 60) begin
      hist[k] = counter;
      if (done) begin
        lat = k;
        break;
      end
      if (k == poke_at) begin
        start    = 1'b1;
        row_size = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (done !== 1'b0 || result !== '0 || counter !== 32'd0) begin
      failures++;
      $display("FAIL reset: done=%b result=%0d counter=%0d, need 0/0/0", done, result, counter);
    end
  endtask

  task automatic test_basic;
    int lat;
    mode = 0;
    run_row(32'd8, -1, lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL basic_latency: got %0d need 4", lat);
    end
    checks++;
    if (result !== 48'sd36) begin
      failures++;
      $display("FAIL basic_result: got %0d need 36", result);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hist[i] !== 32'(2 * i)) begin
        failures++;
        $display("FAIL basic_counter[%0d]: got %0d need %0d", i, hist[i], 2 * i);
      end
    end
    checks++;
    if (counter !== 32'd8) begin
      failures++;
      $display("FAIL basic_counter_end: got %0d need 8", counter);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || counter !== 32'd8 || result !== 48'sd36) begin
      failures++;
      $display("FAIL basic_hold: done=%b counter=%0d result=%0d, need 0/8/36", done, counter, result);
    end
  endtask

  task automatic test_chunks;
    int lat;
    mode = 1;
    run_row(32'd32, -1, lat);
    checks++;
    if (lat !== 16 || result !== 48'sd192) begin
      failures++;
      $display("FAIL chunks_const: lat=%0d result=%0d, need 16/192", lat, result);
    end
    checks++;
    if (hist[4] !== 32'd8 || hist[8] !== 32'd16 || hist[12] !== 32'd24) begin
      failures++;
      $display("FAIL chunks_switch: counter %0d/%0d/%0d, need 8/16/24", hist[4], hist[8], hist[12]);
    end
    mode = 3;
    run_row(32'd32, -1, lat);
    checks++;
    if (lat !== 16 || result !== 48'sd80) begin
      failures++;
      $display("FAIL chunks_distinct: lat=%0d result=%0d, need 16/80", lat, result);
    end
  endtask

  task automatic test_tail;
    int lat;
    mode = 0;
    run_row(32'd5, -1, lat);
    checks++;
    if (lat !== 3 || result !== 48'sd15) begin
      failures++;
      $display("FAIL tail_mask: lat=%0d result=%0d, need 3/15", lat, result);
    end
  endtask

  task automatic test_negative;
    int lat;
    mode = 2;
    run_row(32'd8, -1, lat);
    checks++;
    if (lat !== 4 || result !== 48'hFFFF_FFFF_FFA0) begin
      failures++;
      $display("FAIL negative: lat=%0d result=%h, need 4/ffffffffffa0", lat, result);
    end
  endtask

  task automatic test_zero;
    int lat;
    mode = 0;
    run_row(32'd0, -1, lat);
    checks++;
    if (lat !== 0 || result !== '0) begin
      failures++;
      $display("FAIL zero_row: lat=%0d result=%0d, need done at first sample/0", lat, result);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    mode = 0;
    run_row(32'd8, 1, lat);
    checks++;
    if (lat !== 4 || result !== 48'sd36) begin
      failures++;
      $display("FAIL ignore_start: lat=%0d result=%0d, need 4/36", lat, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || counter !== 32'd8) begin
      failures++;
      $display("FAIL ignore_start_idle: done=%b counter=%0d, need 0/8", done, counter);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    mode = 1;
    @(negedge clk);
    start    = 1'b1;
    row_size = 32'd32;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (done !== 1'b0 || result !== '0 || counter !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: done=%b result=%0d counter=%0d, need 0/0/0", done, result, counter);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || counter !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_idle: done=%b counter=%0d, need 0/0", done, counter);
    end
    mode = 0;
    run_row(32'd8, -1, lat);
    checks++;
    if (lat !== 4 || result !== 48'sd36) begin
      failures++;
      $display("FAIL reset_mid_restart: lat=%0d result=%0d, need 4/36", lat, result);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mode     = 0;
    rst      = 1'b1;
    start    = 1'b0;
    row_size = '0;
    test_reset();
    test_basic();
    test_chunks();
    test_tail();
    test_negative();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
